// File: rtl/closest_hit.sv
// Closest-hit reduction: keeps the nearest qualifying triangle hit per ray.
// Optional per-ray qualifying hit counter enabled by CLOSEST_HIT_COUNT_EN.
module closest_hit #(
    parameter logic signed [31:0] MIN_T = 32'sh00000000,
    parameter int                 IDX_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_hit,
    input  logic signed [31:0]      i_t,
    input  logic [2:0][31:0]        i_normal,
    input  logic [IDX_W-1:0]        i_tri_id,
    input  logic                    i_last,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_hit,
    output logic signed [31:0]      o_t,
    output logic [2:0][31:0]        o_normal,
`ifdef CLOSEST_HIT_COUNT_EN
    output logic [IDX_W:0]          o_hit_cnt,
`endif
    output logic [IDX_W-1:0]        o_tri_id
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;

    localparam logic signed [31:0] T_NONE = 32'sh7FFFFFFF;

    logic [1:0]         state;
    logic               ready_q;
    logic               best_hit;
    logic signed [31:0] best_t;
    logic [2:0][31:0]   best_normal;
    logic [IDX_W-1:0]   best_id;

    logic accept;
    logic xfer;
    logic qual;
    logic take;

    assign accept = i_valid && ready_q;
    assign xfer   = (state == OUT) && i_ready;
    assign qual   = i_hit && (i_t >= MIN_T);
    // Strict less-than keeps the earlier triangle on equal distance.
    assign take   = accept && qual && (!best_hit || (i_t < best_t));

    assign o_ready  = ready_q;
    assign o_valid  = (state == OUT);
    assign o_hit    = best_hit;
    assign o_t      = best_t;
    assign o_normal = best_normal;
    assign o_tri_id = best_id;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        state   <= i_last ? OUT : ACCUM;
                        ready_q <= !i_last;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (xfer) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            best_hit    <= 1'b0;
            best_t      <= T_NONE;
            best_normal <= '0;
            best_id     <= '0;
        end else if (xfer) begin
            best_hit    <= 1'b0;
            best_t      <= T_NONE;
            best_normal <= '0;
            best_id     <= '0;
        end else if (take) begin
            best_hit    <= 1'b1;
            best_t      <= i_t;
            best_normal <= i_normal;
            best_id     <= i_tri_id;
        end
    end

`ifdef CLOSEST_HIT_COUNT_EN
    logic [IDX_W:0] cnt;

    assign o_hit_cnt = cnt;

    // Accepts never happen in OUT, so the count is frozen there.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= '0;
        end else if (accept && qual && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_closest_hit.sv
// Scoreboard bench for closest_hit; expected records queued by stimulus,
// popped and compared by a monitor on every output transfer.
module tb_closest_hit;

    localparam int IDX_W = 16;
    localparam logic signed [31:0] MIN_T = 32'sh00008000;

    typedef struct {
        logic              hit;
        logic [31:0]       t;
        logic [2:0][31:0]  normal;
        logic [IDX_W-1:0]  id;
        int                cnt;
    } rec_t;

    logic                   i_clk;
    logic                   i_rst;
    logic                   i_valid;
    logic                   o_ready;
    logic                   i_hit;
    logic signed [31:0]     i_t;
    logic [2:0][31:0]       i_normal;
    logic [IDX_W-1:0]       i_tri_id;
    logic                   i_last;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_hit;
    logic signed [31:0]     o_t;
    logic [2:0][31:0]       o_normal;
    logic [IDX_W-1:0]       o_tri_id;
`ifdef CLOSEST_HIT_COUNT_EN
    logic [IDX_W:0]         o_hit_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    rec_t exp_q[$];

    closest_hit #(.MIN_T(MIN_T), .IDX_W(IDX_W)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_hit    (i_hit),
        .i_t      (i_t),
        .i_normal (i_normal),
        .i_tri_id (i_tri_id),
        .i_last   (i_last),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_hit    (o_hit),
        .o_t      (o_t),
        .o_normal (o_normal),
`ifdef CLOSEST_HIT_COUNT_EN
        .o_hit_cnt(o_hit_cnt),
`endif
        .o_tri_id (o_tri_id)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [2:0][31:0] mk_norm(input int id);
        logic [2:0][31:0] n;
        n[0] = 32'h00010000 + id;
        n[1] = 32'h00200000 + id;
        n[2] = 32'hFFF00000 + id;
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_rec(input logic hit, input logic [31:0] t,
                              input int id, input int cnt);
        rec_t r;
        r.hit    = hit;
        r.t      = t;
        r.normal = hit ? mk_norm(id) : '0;
        r.id     = hit ? IDX_W'(id) : '0;
        r.cnt    = cnt;
        exp_q.push_back(r);
    endtask

    task automatic send(input logic hit, input logic [31:0] t,
                        input int id, input logic last);
        int n;
        i_valid  = 1'b1;
        i_hit    = hit;
        i_t      = t;
        i_normal = mk_norm(id);
        i_tri_id = IDX_W'(id);
        i_last   = last;
        n = 0;
        while (!o_ready && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: o_ready stuck 0 for id %0d", id);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_hit   = 1'b1;
        i_t     = 32'sh00000001;
        i_tri_id = '1;
        if (last) chk("latency_valid", 64'(o_valid), 64'd1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d records outstanding",
                     exp_q.size());
        end
    endtask

    // Monitor: a record transfers at the next rising edge.
    initial begin
        rec_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_record: id %0d", o_tri_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("rec_hit", 64'(o_hit), 64'(e.hit));
                    chk("rec_t", 64'(o_t), 64'(e.t));
                    chk("rec_nx", 64'(o_normal[0]), 64'(e.normal[0]));
                    chk("rec_nz", 64'(o_normal[2]), 64'(e.normal[2]));
                    chk("rec_id", 64'(o_tri_id), 64'(e.id));
`ifdef CLOSEST_HIT_COUNT_EN
                    chk("rec_cnt", 64'(o_hit_cnt), 64'(e.cnt));
`endif
                end
            end
        end
    end

    initial begin
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_hit    = 1'b0;
        i_t      = '0;
        i_normal = '0;
        i_tri_id = '0;
        i_last   = 1'b0;
        i_ready  = 1'b1;
        #1;
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_t", 64'(o_t), 64'h7FFFFFFF);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("post_rst_ready", 64'(o_ready), 64'd1);

        // Closest of three, with ignored garbage between beats.
        expect_rec(1'b1, 32'h00010000, 2, 3);
        send(1'b1, 32'h00030000, 1, 1'b0);
        idle(2);
        send(1'b1, 32'h00010000, 2, 1'b0);
        send(1'b1, 32'h00020000, 3, 1'b1);
        drain();

        // No hits at all.
        expect_rec(1'b0, 32'h7FFFFFFF, 0, 0);
        send(1'b0, 32'h00010000, 20, 1'b0);
        send(1'b0, 32'h00020000, 21, 1'b1);
        drain();

        // Below MIN_T is rejected.
        expect_rec(1'b1, 32'h00020000, 6, 1);
        send(1'b1, 32'h00004000, 5, 1'b0);
        send(1'b1, 32'h00020000, 6, 1'b1);
        drain();

        // Negative t is below MIN_T (signed compare).
        expect_rec(1'b1, 32'h00060000, 12, 1);
        send(1'b1, 32'hFFFF0000, 4, 1'b0);
        send(1'b1, 32'h00060000, 12, 1'b1);
        drain();

        // Tie keeps the earlier triangle.
        expect_rec(1'b1, 32'h00010000, 7, 2);
        send(1'b1, 32'h00010000, 7, 1'b0);
        send(1'b1, 32'h00010000, 8, 1'b1);
        drain();

        // Back-pressure in OUT with a pending beat upstream.
        i_ready = 1'b0;
        expect_rec(1'b1, 32'h00020000, 10, 1);
        expect_rec(1'b1, 32'h00040000, 11, 1);
        send(1'b1, 32'h00020000, 10, 1'b1);
        i_valid  = 1'b1;
        i_hit    = 1'b1;
        i_t      = 32'sh00040000;
        i_normal = mk_norm(11);
        i_tri_id = IDX_W'(11);
        i_last   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            chk("stall_ready", 64'(o_ready), 64'd0);
            chk("stall_valid", 64'(o_valid), 64'd1);
            chk("stall_id", 64'(o_tri_id), 64'd10);
            chk("stall_t", 64'(o_t), 64'h00020000);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("xfer_ready", 64'(o_ready), 64'd1);
        chk("xfer_valid", 64'(o_valid), 64'd0);
        chk("xfer_cleared_t", 64'(o_t), 64'h7FFFFFFF);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("next_valid", 64'(o_valid), 64'd1);
        drain();

        // Reset mid-ray discards the partial result.
        send(1'b1, 32'h00010000, 13, 1'b0);
        send(1'b1, 32'h00011000, 14, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(o_ready), 64'd0);
        chk("midrst_hit", 64'(o_hit), 64'd0);
        chk("midrst_t", 64'(o_t), 64'h7FFFFFFF);
        chk("midrst_id", 64'(o_tri_id), 64'd0);
        chk("midrst_nx", 64'(o_normal[0]), 64'd0);
`ifdef CLOSEST_HIT_COUNT_EN
        chk("midrst_cnt", 64'(o_hit_cnt), 64'd0);
`endif
        @(negedge i_clk);
        i_rst = 1'b0;
        expect_rec(1'b1, 32'h00050000, 9, 1);
        send(1'b1, 32'h00050000, 9, 1'b1);
        drain();
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
